// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave transfer block.
// Covers the FSM state encoding, the mode encoding and the default receive word.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Mode number is {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam logic [31:0] SPI_DEFAULT_RESET_VAL = 32'h1000_234A;

  function automatic logic sample_on_rise(input logic [1:0] mode);
    logic r;
    r = 1'b0;
    case (mode)
      SPI_MODE0, SPI_MODE3: r = 1'b1;
      SPI_MODE1, SPI_MODE2: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input; 2 clk latency.
// The reset value lets idle-high lines (chip select, CPOL=1 clock) come out of reset inactive.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_slave_xfer.sv
// Full-duplex SPI slave, all CPOL/CPHA modes, back-to-back words under one chip select.
// Pin sample edge to rx_valid is 4 clk; tx_data is latched with a one-cycle tx_ready strobe.
module spi_slave_xfer
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               CPOL      = 0,
  parameter int               CPHA      = 0,
  parameter int               TIMEOUT   = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(SPI_DEFAULT_RESET_VAL)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             abort
);

  localparam int         CW          = $clog2(WIDTH);
  localparam int         TW          = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] MODE        = 2'(CPOL * 2 + CPHA);
  localparam logic       SAMPLE_RISE = sample_on_rise(MODE);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

  logic cs_s, sck_s, mosi_s, sck_d;
  logic sck_rise, sck_fall, sample_edge, shift_edge, timeout_hit;
  state_t state, state_nxt;
  logic load, shift, sample, word_done, word_done_q, abort_nxt, cnt_clr;
  logic [CW-1:0]    bit_cnt;
  logic [TW-1:0]    idle_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-2:0] tx_shift;

  sync_2ff #(.RST_VAL(1'b1))     u_cs_sync   (.clk(clk), .reset(reset), .d(cs),   .q(cs_s));
  sync_2ff #(.RST_VAL(1'(CPOL))) u_sck_sync  (.clk(clk), .reset(reset), .d(sck),  .q(sck_s));
  sync_2ff #(.RST_VAL(1'b0))     u_mosi_sync (.clk(clk), .reset(reset), .d(mosi), .q(mosi_s));

  assign miso_oe     = ~cs_s;
  assign sck_rise    = sck_s & ~sck_d;
  assign sck_fall    = ~sck_s & sck_d;
  assign sample_edge = SAMPLE_RISE ? sck_rise : sck_fall;
  // For CPHA=1 the shift edge is the leading edge, so the word load lands on it too
  assign shift_edge  = SAMPLE_RISE ? sck_fall : sck_rise;
  assign timeout_hit = (TIMEOUT > 0) && (idle_cnt == TO_MAX) && (bit_cnt != '0)
                       && !(sck_rise || sck_fall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    sample    = 1'b0;
    word_done = 1'b0;
    abort_nxt = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          state_nxt = ACTIVE;
          load      = (CPHA == 0);
        end
      end
      ACTIVE: begin
        sample    = sample_edge;
        word_done = sample_edge && (bit_cnt == LAST_BIT);
        if (shift_edge && !cs_s) begin
          if (bit_cnt == '0) load  = 1'b1;
          else               shift = 1'b1;
        end
        // A final sample coinciding with cs release still completes the word
        if (cs_s) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
          abort_nxt = !word_done && ((bit_cnt != '0) || sample_edge);
        end else if (timeout_hit) begin
          abort_nxt = 1'b1;
          cnt_clr   = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_d       <= 1'(CPOL);
      bit_cnt     <= '0;
      idle_cnt    <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      miso        <= 1'b0;
      rx_data     <= RESET_VAL;
      rx_valid    <= 1'b0;
      tx_ready    <= 1'b0;
      abort       <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      sck_d       <= sck_s;
      tx_ready    <= load;
      abort       <= abort_nxt;
      word_done_q <= word_done;
      rx_valid    <= word_done_q;
      if (word_done_q) rx_data <= rx_shift;

      if (sck_rise || sck_fall)                 idle_cnt <= '0;
      else if (TIMEOUT > 0 && idle_cnt != TO_MAX) idle_cnt <= idle_cnt + TW'(1);

      if (sample) rx_shift <= {rx_shift[WIDTH-2:0], mosi_s};

      if (cnt_clr || word_done) bit_cnt <= '0;
      else if (sample)          bit_cnt <= bit_cnt + CW'(1);

      if (load) begin
        miso     <= tx_data[WIDTH-1];
        tx_shift <= tx_data[WIDTH-2:0];
      end else if (shift) begin
        miso     <= tx_shift[WIDTH-2];
        tx_shift <= tx_shift << 1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_xfer.sv
// Bench with two slaves: mode 0 / 8-bit / timeout 16, and mode 3 / 32-bit / no timeout.
// An SPI master model drives random words; expectations come from the words exchanged.
module tb_spi_slave_xfer;

  localparam int HALF = 4;

  logic clk = 1'b0;
  logic reset;
  logic cs0, sck0, mosi0, miso0, miso_oe0, tx_ready0, rx_valid0, abort0;
  logic [7:0] tx_data0, rx_data0;
  logic cs1, sck1, mosi1, miso1, miso_oe1, tx_ready1, rx_valid1, abort1;
  logic [31:0] tx_data1, rx_data1;

  int errors = 0;
  int checks = 0;
  int n_rv[2], n_tr[2], n_ab[2];
  logic [31:0] got0[$], got1[$];
  logic [31:0] mw[4], tw[4];
  logic [31:0] last_rx[2];

  always #5 clk = ~clk;

  spi_slave_xfer #(.WIDTH(8), .CPOL(0), .CPHA(0), .TIMEOUT(16), .RESET_VAL(8'hC3)) u_m0 (
    .clk(clk), .reset(reset), .cs(cs0), .sck(sck0), .mosi(mosi0), .miso(miso0),
    .miso_oe(miso_oe0), .tx_data(tx_data0), .tx_ready(tx_ready0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .abort(abort0));

  spi_slave_xfer #(.WIDTH(32), .CPOL(1), .CPHA(1), .TIMEOUT(0)) u_m3 (
    .clk(clk), .reset(reset), .cs(cs1), .sck(sck1), .mosi(mosi1), .miso(miso1),
    .miso_oe(miso_oe1), .tx_data(tx_data1), .tx_ready(tx_ready1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .abort(abort1));

  always @(negedge clk) begin
    if (rx_valid0 === 1'b1) begin n_rv[0]++; got0.push_back({24'h0, rx_data0}); end
    if (rx_valid1 === 1'b1) begin n_rv[1]++; got1.push_back(rx_data1); end
    if (tx_ready0 === 1'b1) n_tr[0]++;
    if (tx_ready1 === 1'b1) n_tr[1]++;
    if (abort0 === 1'b1) n_ab[0]++;
    if (abort1 === 1'b1) n_ab[1]++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] rxd(input int d);
    return (d == 0) ? {24'h0, rx_data0} : rx_data1;
  endfunction

  task automatic set_cs(input int d, input logic v);
    if (d == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic set_tx(input int d, input logic [31:0] v);
    if (d == 0) tx_data0 = v[7:0]; else tx_data1 = v;
  endtask

  // Sends the low nb bits of mo MSB first; lat = {rx_valid 4 clk, rx_valid 3 clk} after the last sample
  task automatic xfer(input int d, input int nb, input logic [31:0] mo,
                      output logic [31:0] mi, output logic [1:0] lat);
    mi  = '0;
    lat = '0;
    for (int i = nb - 1; i >= 0; i--) begin
      if (d == 0) mosi0 = mo[i];
      else begin sck1 = 1'b0; mosi1 = mo[i]; end
      repeat (HALF) @(negedge clk);
      if (d == 0) begin sck0 = 1'b1; mi[i] = miso0; end
      else        begin sck1 = 1'b1; mi[i] = miso1; end
      repeat (HALF - 1) @(negedge clk);
      lat[0] = (d == 0) ? rx_valid0 : rx_valid1;
      @(negedge clk);
      lat[1] = (d == 0) ? rx_valid0 : rx_valid1;
      if (d == 0) sck0 = 1'b0;
    end
  endtask

  task automatic frame(input int d, input int nw);
    int nb, rv, tr, trw, ab;
    logic [31:0] mi, mask, g;
    logic [1:0] lat;
    nb   = (d == 0) ? 8 : 32;
    mask = (d == 0) ? 32'hFF : 32'hFFFF_FFFF;
    rv = n_rv[d]; tr = n_tr[d]; ab = n_ab[d]; trw = tr;
    set_tx(d, tw[0]);
    set_cs(d, 1'b0);
    repeat (HALF) @(negedge clk);
    check("miso_oe_active", (d == 0) ? miso_oe0 : miso_oe1, 32'd1);
    for (int k = 0; k < nw; k++) begin
      xfer(d, nb, mw[k] & mask, mi, lat);
      trw = n_tr[d];
      if (k + 1 < nw) set_tx(d, tw[k+1]);
      check("rx_valid_latency", {30'h0, lat}, 32'd2);
      check("master_rx_word", mi, tw[k] & mask);
    end
    repeat (HALF) @(negedge clk);
    set_cs(d, 1'b1);
    repeat (8) @(negedge clk);
    check("rx_valid_count", n_rv[d] - rv, nw);
    check("tx_ready_count", trw - tr, nw);
    check("abort_count", n_ab[d] - ab, 0);
    for (int k = 0; k < nw; k++) begin
      g = (d == 0) ? got0[rv+k] : got1[rv+k];
      check("rx_word_order", g, mw[k] & mask);
    end
    last_rx[d] = mw[nw-1] & mask;
    check("rx_data_hold", rxd(d), last_rx[d]);
  endtask

  initial begin
    int rv, ab, d, nw;
    logic [31:0] mi, w;
    logic [1:0] lat;
    for (int i = 0; i < 2; i++) begin n_rv[i] = 0; n_tr[i] = 0; n_ab[i] = 0; end
    reset = 1'b0;
    cs0 = 1'b1; sck0 = 1'b0; mosi0 = 1'b0; tx_data0 = 8'h00;
    cs1 = 1'b1; sck1 = 1'b1; mosi1 = 1'b0; tx_data1 = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_rx_data0", rx_data0, 32'hC3);
    check("rst_rx_data1", rx_data1, 32'h1000_234A);
    check("rst_rx_valid0", rx_valid0, 0);
    check("rst_tx_ready0", tx_ready0, 0);
    check("rst_abort0", abort0, 0);
    check("rst_miso0", miso0, 0);
    check("rst_miso_oe0", miso_oe0, 0);
    check("rst_miso_oe1", miso_oe1, 0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    last_rx[0] = 32'hC3;
    last_rx[1] = 32'h1000_234A;

    mw[0] = 32'hA5; tw[0] = 32'h3C;
    frame(0, 1);
    mw[0] = 32'hDEAD_BEEF; tw[0] = 32'h1234_5678;
    frame(1, 1);
    for (int k = 0; k < 3; k++) begin mw[k] = k + 1; tw[k] = $urandom; end
    frame(0, 3);

    for (int r = 0; r < 8; r++) begin
      d  = r % 2;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin mw[k] = $urandom; tw[k] = $urandom; end
      frame(d, nw);
    end

    // sck stalls mid-word long enough to trip the idle timeout
    rv = n_rv[0]; ab = n_ab[0];
    tx_data0 = 8'($urandom);
    cs0 = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(0, 3, $urandom, mi, lat);
    repeat (17) @(negedge clk);
    check("tmo_not_early", n_ab[0] - ab, 0);
    repeat (5) @(negedge clk);
    check("tmo_abort", n_ab[0] - ab, 1);
    xfer(0, 8, 32'h5A, mi, lat);
    check("tmo_next_latency", {30'h0, lat}, 32'd2);
    repeat (HALF) @(negedge clk);
    cs0 = 1'b1;
    repeat (8) @(negedge clk);
    check("tmo_rx_valid_count", n_rv[0] - rv, 1);
    check("tmo_rx_data", rx_data0, 32'h5A);
    check("tmo_abort_total", n_ab[0] - ab, 1);

    // final sample edge and cs release land together
    w = 32'($urandom_range(0, 255));
    rv = n_rv[0]; ab = n_ab[0];
    cs0 = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(0, 7, w >> 1, mi, lat);
    mosi0 = w[0];
    repeat (HALF) @(negedge clk);
    sck0 = 1'b1;
    cs0  = 1'b1;
    repeat (8) @(negedge clk);
    sck0 = 1'b0;
    repeat (6) @(negedge clk);
    check("simul_rx_valid", n_rv[0] - rv, 1);
    check("simul_no_abort", n_ab[0] - ab, 0);
    check("simul_rx_data", rx_data0, w);

    // reset mid-word
    rv = n_rv[0];
    tx_data0 = 8'hFF;
    cs0 = 1'b0;
    repeat (HALF) @(negedge clk);
    xfer(0, 4, $urandom, mi, lat);
    check("pre_reset_miso", miso0, 1);
    reset = 1'b0;
    #1;
    check("arst_rx_data", rx_data0, 32'hC3);
    check("arst_miso", miso0, 0);
    check("arst_miso_oe", miso_oe0, 0);
    cs0 = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("arst_no_rx_valid", n_rv[0] - rv, 0);
    check("arst_rx_data1", rx_data1, 32'h1000_234A);
    last_rx[0] = 32'hC3;
    last_rx[1] = 32'h1000_234A;

    // partial words dropped on cs release
    for (int dd = 0; dd < 2; dd++) begin
      rv = n_rv[dd]; ab = n_ab[dd];
      set_tx(dd, $urandom);
      set_cs(dd, 1'b0);
      repeat (HALF) @(negedge clk);
      xfer(dd, (dd == 0) ? 5 : 13, $urandom, mi, lat);
      repeat (2) @(negedge clk);
      set_cs(dd, 1'b1);
      repeat (10) @(negedge clk);
      check("partial_abort", n_ab[dd] - ab, 1);
      check("partial_no_rx_valid", n_rv[dd] - rv, 0);
      check("partial_rx_hold", rxd(dd), last_rx[dd]);
    end

    for (int k = 0; k < 2; k++) begin mw[k] = $urandom; tw[k] = $urandom; end
    frame(0, 1);
    frame(1, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_xfer.md
Name: spi_slave_xfer

Overview:
Full-duplex, parametrised SPI slave. It is the successor of the input-only SPI receiver and feeds the PID coefficient and setpoint registers. It supports all four CPOL/CPHA modes, configurable word width, and back-to-back words within one chip-select window. Captured words are delivered with a one-cycle valid strobe, and transmit words are loaded with a matching ready strobe. Partial words are dropped on chip-select release or SCK timeout.

Parameters:
WIDTH, 32, bits per word (>=2)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
TIMEOUT, 0, clk cycles without an SCK edge mid-word before abort (0 = disabled)
RESET_VAL, 32'h1000234A, reset value of rx_data (default coefficient set)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  asynchronous, active-low reset
cs  in  1  chip select, active-low, asynchronous to clk
sck  in  1  SPI clock, asynchronous to clk
mosi  in  1  serial data in, MSB first
miso  out  1  serial data out, MSB first
miso_oe  out  1  1 while the synchronised cs is low
tx_data  in  WIDTH  word to transmit
tx_ready  out  1  one-cycle pulse when tx_data is latched
rx_data  out  WIDTH  last complete received word; holds between words
rx_valid  out  1  one-cycle pulse when rx_data updates
abort  out  1  one-cycle pulse when a partial word is discarded

Behaviour:
- Reset (reset=0, asynchronous): rx_data=RESET_VAL; rx_valid, tx_ready and abort = 0; miso=0; miso_oe=0; bit counter=0; shift registers=0; synchronisers: cs=1, sck=CPOL, mosi=0.
- cs, sck and mosi each pass through a 2-FF synchroniser. Edges are detected on the synchronised sck against a registered copy. sck frequency must be <= clk/4.
- Leading edge = rising if CPOL=0, else falling. The sample edge is the leading edge when CPHA=0 and the trailing edge when CPHA=1. The other edge is the shift edge.
- States: IDLE, ACTIVE.
  - IDLE -> ACTIVE when synchronised cs falls.
  - ACTIVE -> IDLE when synchronised cs rises.
- Word load: on cs fall (CPHA=0), or on the first leading edge (CPHA=1), tx_data is latched into tx_shift and tx_ready pulses.
  - For CPHA=0, miso takes tx_data[WIDTH-1] on the same cycle.
  - The load repeats at every word boundary in ACTIVE.
- Sample edge: rx_shift <= {rx_shift[WIDTH-2:0], mosi_sync}; bit counter increments.
- Shift edge: miso <= next tx_shift bit. For CPHA=1, the first leading edge loads the word and drives its MSB.
- Word complete: the bit counter reaches WIDTH-1 on a sample edge. Then:
  - rx_data <= the completed word, and rx_valid pulses on the following clk.
  - The counter wraps to 0.
  - Latency from the pin-level sample edge to rx_valid is 4 clk cycles (2 sync + 1 edge detect + 1 output register).
- rx_data only updates on a complete word; the partial shift register is never visible.
- cs rise with counter != 0: abort pulses, counter is cleared, rx_data is unchanged, no rx_valid. cs rise with counter == 0 gives no abort.
- Timeout (TIMEOUT>0): an idle counter clears on every sck edge. If it reaches TIMEOUT while ACTIVE with counter != 0:
  - abort pulses and the counter clears.
  - The state stays ACTIVE, and the next word reloads tx_data at the next word boundary.
- Simultaneous final sample edge and cs rise in the same clk: the word completes (rx_valid pulses) and abort does not.
- Reset asserted mid-word: all state returns to reset values immediately, with no rx_valid.
- Counter width is $clog2(WIDTH); WIDTH need not be a power of two.
- The idle timeout counter width is $clog2(TIMEOUT+1).

Decomposition:
- Package spi_pkg: state enum (IDLE, ACTIVE), SPI mode encoding constants, and the default RESET_VAL.
- Sub-module sync_2ff (parametrised reset value), instantiated three times for cs, sck and mosi.

Test Plan:
- Mode 0, WIDTH=8, tx_data=8'h3C, master sends 8'hA5 -> rx_data=8'hA5 with one rx_valid pulse 4 clk after the 8th rising edge; master receives 8'h3C; one tx_ready pulse.
- Mode 3 (CPOL=1, CPHA=1), WIDTH=32, master sends 32'hDEADBEEF -> rx_data=32'hDEADBEEF; master receives tx_data 32'h12345678 intact.
- Mode 0, WIDTH=8, 3 words 8'h01, 8'h02, 8'h03 under one cs -> three rx_valid pulses in order, three tx_ready pulses, no abort.
- 5 bits sent then cs rises -> one abort pulse; rx_data stays at the previous value (RESET_VAL after reset); no rx_valid.
- TIMEOUT=16, sck stalls 20 clk after 3 bits with cs low -> abort pulses at idle count 16; a following full word 8'h5A is received correctly.
- reset pulled low after 4 bits -> rx_data=RESET_VAL, miso=0, miso_oe=0 asynchronously; after release, a full new word is received correctly.
